// File: rtl/npc_pkg.sv
// Shared NPC encodings: sequencer state encoding and the decoded-field values
// that the decoder and the exec sequencer must agree on.
package npc_pkg;

    localparam logic [2:0] WD_MEM    = 3'b100;
    localparam logic [2:0] CSR_ECALL = 3'b010;
    localparam logic [2:0] CSR_MRET  = 3'b011;
    localparam logic [2:0] CSR_RW    = 3'b101;
    localparam logic [2:0] CSR_RS    = 3'b110;

    localparam logic [2:0] ST_IF_REQ  = 3'd0;
    localparam logic [2:0] ST_IF_WAIT = 3'd1;
    localparam logic [2:0] ST_EX      = 3'd2;
    localparam logic [2:0] ST_LS_REQ  = 3'd3;
    localparam logic [2:0] ST_LS_WAIT = 3'd4;
    localparam logic [2:0] ST_ERR     = 3'd5;

    typedef enum logic [2:0] {
        S_IF_REQ  = ST_IF_REQ,
        S_IF_WAIT = ST_IF_WAIT,
        S_EX      = ST_EX,
        S_LS_REQ  = ST_LS_REQ,
        S_LS_WAIT = ST_LS_WAIT,
        S_ERR     = ST_ERR
    } seq_state_e;

    function automatic logic is_mem_op(input logic mem_write, input logic [2:0] wd_src);
        return mem_write | (wd_src == WD_MEM);
    endfunction

    function automatic logic is_csr_write(input logic [2:0] csr_ctr);
        return (csr_ctr == CSR_RW) || (csr_ctr == CSR_RS);
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Per-state stall watchdog: counts cycles spent in a waiting state and flags
// the last permitted cycle so the sequencer can divert to its error state.
module seq_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 32'd0) ? $clog2(TIMEOUT + 32'd1) : 1;
    // Count value seen during the TIMEOUT-th cycle of a state (first cycle reads 0).
    localparam logic [CW-1:0] LIMIT = (TIMEOUT > 32'd0) ? CW'(TIMEOUT - 32'd1) : '0;
    localparam logic ENABLED = (TIMEOUT != 32'd0);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Next count: clear on state change, advance while waiting.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && ENABLED) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = ENABLED && en && (count_q == LIMIT);

endmodule

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/execute/load-store sequencer; owns the IFU/LSU handshakes
// and gates every architectural write so each instruction commits once.
module exec_sequencer
    import npc_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    output logic       ifu_req_valid,
    input  logic       ifu_req_ready,
    input  logic       ifu_resp_valid,
    output logic       ifu_resp_ready,
    output logic       inst_we,
    input  logic       reg_write,
    input  logic       mem_write,
    input  logic [2:0] wd_src,
    input  logic [2:0] csr_ctr,
    output logic       lsu_req_valid,
    output logic       lsu_req_wen,
    input  logic       lsu_req_ready,
    input  logic       lsu_resp_valid,
    output logic       lsu_resp_ready,
    output logic       rf_we,
    output logic       pc_we,
    output logic       csr_we,
    output logic       ecall_commit,
    output logic       mret_commit,
    output logic       retire,
    output logic       err
);

    seq_state_e state_q;
    seq_state_e state_d;
    logic       wd_en;
    logic       wd_clr;
    logic       wd_expired;

    assign wd_en  = (state_q == S_IF_REQ) || (state_q == S_IF_WAIT) ||
                    (state_q == S_LS_REQ) || (state_q == S_LS_WAIT);
    assign wd_clr = (state_d != state_q);

    seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .en      (wd_en),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IF_REQ;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and state-gated outputs; everything is forced low while in reset.
    always_comb begin
        state_d        = state_q;
        ifu_req_valid  = 1'b0;
        ifu_resp_ready = 1'b0;
        inst_we        = 1'b0;
        lsu_req_valid  = 1'b0;
        lsu_req_wen    = 1'b0;
        lsu_resp_ready = 1'b0;
        rf_we          = 1'b0;
        pc_we          = 1'b0;
        csr_we         = 1'b0;
        ecall_commit   = 1'b0;
        mret_commit    = 1'b0;
        retire         = 1'b0;
        err            = 1'b0;
        if (rst) begin
            state_d = S_IF_REQ;
        end else begin
            case (state_q)
                S_IF_REQ: begin
                    ifu_req_valid = 1'b1;
                    if (ifu_req_ready) begin
                        state_d = S_IF_WAIT;
                    end else if (wd_expired) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_IF_REQ;
                    end
                end
                S_IF_WAIT: begin
                    ifu_resp_ready = 1'b1;
                    if (ifu_resp_valid) begin
                        inst_we = 1'b1;
                        state_d = S_EX;
                    end else if (wd_expired) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_IF_WAIT;
                    end
                end
                S_EX: begin
                    if (is_mem_op(mem_write, wd_src)) begin
                        state_d = S_LS_REQ;
                    end else begin
                        rf_we        = reg_write;
                        pc_we        = 1'b1;
                        retire       = 1'b1;
                        csr_we       = is_csr_write(csr_ctr);
                        ecall_commit = (csr_ctr == CSR_ECALL);
                        mret_commit  = (csr_ctr == CSR_MRET);
                        state_d      = S_IF_REQ;
                    end
                end
                S_LS_REQ: begin
                    lsu_req_valid = 1'b1;
                    lsu_req_wen   = mem_write;
                    if (lsu_req_ready) begin
                        state_d = S_LS_WAIT;
                    end else if (wd_expired) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LS_REQ;
                    end
                end
                S_LS_WAIT: begin
                    lsu_resp_ready = 1'b1;
                    if (lsu_resp_valid) begin
                        // Stores never write rd even if the decoder flags it.
                        rf_we   = reg_write & ~mem_write;
                        pc_we   = 1'b1;
                        retire  = 1'b1;
                        state_d = S_IF_REQ;
                    end else if (wd_expired) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LS_WAIT;
                    end
                end
                S_ERR: begin
                    err     = 1'b1;
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_ERR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_sequencer.sv
// Cycle-by-cycle vector bench for exec_sequencer (TIMEOUT=4), plus a
// back-to-back retire sequence.
module tb_exec_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_ready, inst_we;
    logic       reg_write, mem_write;
    logic [2:0] wd_src, csr_ctr;
    logic       lsu_req_valid, lsu_req_wen, lsu_req_ready, lsu_resp_valid, lsu_resp_ready;
    logic       rf_we, pc_we, csr_we, ecall_commit, mret_commit, retire, err;

    exec_sequencer #(.TIMEOUT(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .ifu_req_valid  (ifu_req_valid),
        .ifu_req_ready  (ifu_req_ready),
        .ifu_resp_valid (ifu_resp_valid),
        .ifu_resp_ready (ifu_resp_ready),
        .inst_we        (inst_we),
        .reg_write      (reg_write),
        .mem_write      (mem_write),
        .wd_src         (wd_src),
        .csr_ctr        (csr_ctr),
        .lsu_req_valid  (lsu_req_valid),
        .lsu_req_wen    (lsu_req_wen),
        .lsu_req_ready  (lsu_req_ready),
        .lsu_resp_valid (lsu_resp_valid),
        .lsu_resp_ready (lsu_resp_ready),
        .rf_we          (rf_we),
        .pc_we          (pc_we),
        .csr_we         (csr_we),
        .ecall_commit   (ecall_commit),
        .mret_commit    (mret_commit),
        .retire         (retire),
        .err            (err)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] O_IFV   = 13'h1000;
    localparam logic [12:0] O_IFR   = 13'h0800;
    localparam logic [12:0] O_IWE   = 13'h0400;
    localparam logic [12:0] O_LSV   = 13'h0200;
    localparam logic [12:0] O_LWEN  = 13'h0100;
    localparam logic [12:0] O_LSR   = 13'h0080;
    localparam logic [12:0] O_RF    = 13'h0040;
    localparam logic [12:0] O_PC    = 13'h0020;
    localparam logic [12:0] O_CSR   = 13'h0010;
    localparam logic [12:0] O_ECALL = 13'h0008;
    localparam logic [12:0] O_MRET  = 13'h0004;
    localparam logic [12:0] O_RET   = 13'h0002;
    localparam logic [12:0] O_ERR   = 13'h0001;
    localparam logic [12:0] O_NONE  = 13'h0000;

    // handshake inputs {ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid}
    localparam logic [3:0] H_0   = 4'b0000;
    localparam logic [3:0] H_IRR = 4'b1000;
    localparam logic [3:0] H_IRV = 4'b0100;
    localparam logic [3:0] H_LRR = 4'b0010;
    localparam logic [3:0] H_LRV = 4'b0001;

    // decoded fields {reg_write, mem_write, wd_src, csr_ctr}
    localparam logic [7:0] D_ALU   = {1'b1, 1'b0, 3'b000, 3'b000};
    localparam logic [7:0] D_LD    = {1'b1, 1'b0, 3'b100, 3'b000};
    localparam logic [7:0] D_ST    = {1'b0, 1'b1, 3'b000, 3'b000};
    localparam logic [7:0] D_CSRRW = {1'b1, 1'b0, 3'b000, 3'b101};
    localparam logic [7:0] D_CSRRS = {1'b0, 1'b0, 3'b000, 3'b110};
    localparam logic [7:0] D_ECALL = {1'b0, 1'b0, 3'b000, 3'b010};
    localparam logic [7:0] D_MRET  = {1'b0, 1'b0, 3'b000, 3'b011};

    typedef struct {
        string       tag;
        logic        r;
        logic [3:0]  hs;
        logic [7:0]  dec;
        logic [12:0] exp;
    } vec_t;

    vec_t vecs[$];
    int   tests = 0;
    int   fails = 0;

    logic [12:0] outs;
    assign outs = {ifu_req_valid, ifu_resp_ready, inst_we, lsu_req_valid, lsu_req_wen,
                   lsu_resp_ready, rf_we, pc_we, csr_we, ecall_commit, mret_commit,
                   retire, err};

    task automatic add(input string tag, input logic r, input logic [3:0] hs,
                       input logic [7:0] dec, input logic [12:0] exp);
        vec_t v;
        v.tag = tag; v.r = r; v.hs = hs; v.dec = dec; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic r, input logic [3:0] hs, input logic [7:0] dec);
        rst = r;
        {ifu_req_ready, ifu_resp_valid, lsu_req_ready, lsu_resp_valid} = hs;
        {reg_write, mem_write, wd_src, csr_ctr} = dec;
    endtask

    task automatic check(input string tag, input logic [12:0] act, input logic [12:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: outputs got %h expected %h", tag, act, exp);
        end
    endtask

    initial begin
        int rcount;
        logic [12:0] e;
        drive(1'b1, H_0, 8'h00);

        add("rst_stale",      1'b1, H_IRR | H_IRV | H_LRV, D_ALU, O_NONE);
        add("alu_ifreq",      1'b0, H_IRR, D_ALU, O_IFV);
        add("alu_ifwait",     1'b0, H_IRV, D_ALU, O_IFR | O_IWE);
        add("alu_ex",         1'b0, H_0,   D_ALU, O_RF | O_PC | O_RET);
        add("ld_ifreq",       1'b0, H_IRR, D_LD, O_IFV);
        add("ld_ifwait_stl",  1'b0, H_0,   D_LD, O_IFR);
        add("ld_ifwait",      1'b0, H_IRV, D_LD, O_IFR | O_IWE);
        add("ld_ex",          1'b0, H_0,   D_LD, O_NONE);
        add("ld_req1_stale",  1'b0, H_LRV, D_LD, O_LSV);
        add("ld_req2",        1'b0, H_0,   D_LD, O_LSV);
        add("ld_req3",        1'b0, H_0,   D_LD, O_LSV);
        add("ld_req4_wdedge", 1'b0, H_LRR, D_LD, O_LSV);
        add("ld_wait1",       1'b0, H_0,   D_LD, O_LSR);
        add("ld_wait2",       1'b0, H_LRV, D_LD, O_LSR | O_RF | O_PC | O_RET);
        add("st_ifreq_stale", 1'b0, H_IRR | H_IRV, D_ST, O_IFV);
        add("st_ifwait",      1'b0, H_IRV, D_ST, O_IFR | O_IWE);
        add("st_ex",          1'b0, H_0,   D_ST, O_NONE);
        add("st_req",         1'b0, H_LRR, D_ST, O_LSV | O_LWEN);
        add("st_wait",        1'b0, H_LRV, D_ST, O_LSR | O_PC | O_RET);
        add("rw_ifreq",       1'b0, H_IRR, D_CSRRW, O_IFV);
        add("rw_ifwait",      1'b0, H_IRV, D_CSRRW, O_IFR | O_IWE);
        add("rw_ex",          1'b0, H_0,   D_CSRRW, O_RF | O_PC | O_CSR | O_RET);
        add("rs_ifreq",       1'b0, H_IRR, D_CSRRS, O_IFV);
        add("rs_ifwait",      1'b0, H_IRV, D_CSRRS, O_IFR | O_IWE);
        add("rs_ex",          1'b0, H_0,   D_CSRRS, O_PC | O_CSR | O_RET);
        add("ec_ifreq",       1'b0, H_IRR, D_ECALL, O_IFV);
        add("ec_ifwait",      1'b0, H_IRV, D_ECALL, O_IFR | O_IWE);
        add("ec_ex",          1'b0, H_0,   D_ECALL, O_PC | O_ECALL | O_RET);
        add("mr_ifreq",       1'b0, H_IRR, D_MRET, O_IFV);
        add("mr_ifwait",      1'b0, H_IRV, D_MRET, O_IFR | O_IWE);
        add("mr_ex",          1'b0, H_0,   D_MRET, O_PC | O_MRET | O_RET);
        add("rl_ifreq",       1'b0, H_IRR, D_LD, O_IFV);
        add("rl_ifwait",      1'b0, H_IRV, D_LD, O_IFR | O_IWE);
        add("rl_ex",          1'b0, H_0,   D_LD, O_NONE);
        add("rl_req",         1'b0, H_LRR, D_LD, O_LSV);
        add("rl_wait",        1'b0, H_0,   D_LD, O_LSR);
        add("rl_rst",         1'b1, H_LRV, D_LD, O_NONE);
        add("rl_late_resp",   1'b0, H_LRV, D_LD, O_IFV);
        add("wd_ifreq2",      1'b0, H_LRV, D_LD, O_IFV);
        add("wd_ifreq3",      1'b0, H_0,   D_LD, O_IFV);
        add("wd_ifreq4",      1'b0, H_0,   D_LD, O_IFV);
        add("wd_err",         1'b0, H_0,   D_LD, O_ERR);
        add("wd_err_hold1",   1'b0, H_IRR | H_IRV | H_LRR | H_LRV, D_ALU, O_ERR);
        add("wd_err_hold2",   1'b0, H_IRR | H_IRV | H_LRR | H_LRV, D_ST, O_ERR);
        add("wd_rst",         1'b1, H_0,   D_ALU, O_NONE);
        add("wd_after_rst",   1'b0, H_IRR, D_ALU, O_IFV);
        add("wdw_wait1",      1'b0, H_0,   D_ALU, O_IFR);
        add("wdw_wait2",      1'b0, H_0,   D_ALU, O_IFR);
        add("wdw_wait3",      1'b0, H_0,   D_ALU, O_IFR);
        add("wdw_wait4",      1'b0, H_0,   D_ALU, O_IFR);
        add("wdw_err",        1'b0, H_IRV, D_ALU, O_ERR);
        add("wdb_rst",        1'b1, H_0,   D_ALU, O_NONE);
        add("wdb_ifreq",      1'b0, H_IRR, D_ALU, O_IFV);
        add("wdb_wait1",      1'b0, H_0,   D_ALU, O_IFR);
        add("wdb_wait2",      1'b0, H_0,   D_ALU, O_IFR);
        add("wdb_wait3",      1'b0, H_0,   D_ALU, O_IFR);
        add("wdb_wait4_hs",   1'b0, H_IRV, D_ALU, O_IFR | O_IWE);
        add("wdb_ex",         1'b0, H_0,   D_ALU, O_RF | O_PC | O_RET);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].r, vecs[i].hs, vecs[i].dec);
            #2;
            check(vecs[i].tag, outs, vecs[i].exp);
        end

        // Back-to-back ALU ops with handshakes always available: one retire every 3 cycles.
        @(negedge clk);
        drive(1'b1, H_0, D_ALU);
        #2;
        check("b2b_rst", outs, O_NONE);
        rcount = 0;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            drive(1'b0, H_IRR | H_IRV, D_ALU);
            #2;
            case (c % 3)
                0:       e = O_IFV;
                1:       e = O_IFR | O_IWE;
                default: e = O_RF | O_PC | O_RET;
            endcase
            check("b2b_cycle", outs, e);
            if (retire === 1'b1) rcount++;
        end
        tests++;
        if (rcount != 3) begin
            fails++;
            $display("FAIL b2b_retire_count: got %0d expected 3", rcount);
        end

        @(negedge clk);
        drive(1'b1, H_0, 8'h00);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
